alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares the single-cycle ALU between NUM_REQ requesters, e.g. the EX stage and the branch/address unit.
//  Each requester issues an operation (a, b, alu_ctrl) over a valid/ready handshake.
//  A 3-state FSM grants one requester, drives registered operands to the ALU and captures result/zero.
//  It then returns them over a per-requester valid/ready response channel.
// PARAMETERS
//  XLEN     32  operand/result width
//  NUM_REQ  2   number of requesters, legal range 2..8
// PORTS
//  clk         in   1             system clock; all state updates on rising edge
//  rst         in   1             synchronous, active-high reset
//  req_valid   in   NUM_REQ       per-requester operation valid
//  req_ready   out  NUM_REQ       per-requester accept (one-hot or zero)
//  req_a       in   NUM_REQ*XLEN  operand A; requester i at [i*XLEN +: XLEN]
//  req_b       in   NUM_REQ*XLEN  operand B; same packing as req_a
//  req_ctrl    in   NUM_REQ*4     ALU op code; requester i at [i*4 +: 4]
//  rsp_valid   out  NUM_REQ       response valid; one-hot or zero
//  rsp_ready   in   NUM_REQ       response accept
//  rsp_result  out  XLEN          result; shared by all requesters, qualified by rsp_valid
//  rsp_zero    out  1             zero flag for rsp_result
//  alu_a       out  XLEN          registered operand A to the ALU
//  alu_b       out  XLEN          registered operand B to the ALU
//  alu_ctrl    out  4             registered op code to the ALU
//  alu_result  in   XLEN          ALU combinational result
//  alu_zero    in   1             ALU combinational zero flag
//  busy        out  1             high whenever the FSM is not in IDLE
// BEHAVIOUR
//  Reset (rst=1 at a clk edge)
//   - state=IDLE, grant=0, priority pointer=0.
//   - alu_a, alu_b, alu_ctrl, rsp_result, rsp_zero all 0.
//   - req_ready, rsp_valid, busy all 0.
//   - Reset mid-operation aborts the operation; its response is never issued.
//  FSM
//   - IDLE: winner = first requester with req_valid high, scanning from the priority pointer upward with wrap.
//     req_ready[winner] is high combinationally in this same cycle.
//     On the accept edge: latch a/b/ctrl into alu_* regs, record grant, go to EXEC.
//     No winner: stay in IDLE.
//   - EXEC: ALU evaluates the registered operands.
//     At the edge: rsp_result<=alu_result, rsp_zero<=alu_zero, go to RESP.
//   - RESP: rsp_valid[grant]=1.
//     On rsp_valid&rsp_ready: pointer <= (grant+1) mod NUM_REQ, go to IDLE.
//     Otherwise stay in RESP with rsp_result/rsp_zero held stable.
//  Handshake and timing rules
//   - req_ready is 0 outside IDLE.
//   - Latency: accept at edge N gives rsp_valid high in cycle N+2.
//   - Minimum issue interval is 3 cycles.
//   - Requesters hold req_valid and operands until accepted; dropping valid before accept is legal and ignored.
//   - rsp_ready of non-granted requesters is ignored.
//   - A requester may re-assert req_valid in the same cycle it completes a response.
//     It is considered in the next IDLE cycle.
//  Arithmetic and width rules
//   - No arithmetic in this block; op codes pass through unmodified.
//   - The ALU returns 0 (zero=1) for undefined codes.
//   - alu_* hold their last values outside EXEC.
//   - busy = (state != IDLE).
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN
//   - Defined: priority pointer rotates as above. No requester is starved: each waits at most NUM_REQ-1 grants.
//   - Undefined: fixed priority, requester 0 highest. Pointer is tied to 0; lower indices may starve higher ones.
// TESTING
//  1. rst high 2 cycles, then low, no requests -> req_ready=0, rsp_valid=0, busy=0, alu_a/b/ctrl=0.
//  2. req0: a=5, b=3, ctrl=4'b0001 -> accepted cycle 0; rsp_valid[0]=1 in cycle 2; rsp_result=2, rsp_zero=0.
//  3. Both valid continuously; req0 ADD 1+1, req1 AND 0xF0&0x0F; rsp_ready=1.
//     With macro: grant order 0,1,0,1; rsp_result 2 / 0 with rsp_zero 0 / 1.
//     Without macro: only requester 0 is ever granted.
//  4. rsp_ready[0] low for 5 cycles in RESP -> rsp_valid[0] and result held constant.
//     req_ready stays 0 for requester 1 until the handshake completes.
//  5. rst pulsed during EXEC of req1 (OR 0x1|0x2) -> no rsp_valid; state IDLE, pointer 0.
//     Next req1 is served normally with result 3.
//  6. req0 ctrl=4'b1111, a=7, b=9 -> rsp_result=0, rsp_zero=1 after 2 cycles.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one single-cycle ALU among NUM_REQ requesters through an IDLE/EXEC/RESP FSM.
// Define ARB_ROUND_ROBIN_EN for a rotating priority pointer; otherwise requester 0 always has the highest priority.
module alu_share_arbiter #(
  parameter int XLEN    = 32,
  parameter int NUM_REQ = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*XLEN-1:0] req_a,
  input  logic [NUM_REQ*XLEN-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]    req_ctrl,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [XLEN-1:0]         rsp_result,
  output logic                    rsp_zero,
  output logic [XLEN-1:0]         alu_a,
  output logic [XLEN-1:0]         alu_b,
  output logic [3:0]              alu_ctrl,
  input  logic [XLEN-1:0]         alu_result,
  input  logic                    alu_zero,
  output logic                    busy
);

  localparam int IDXW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] grant_q, grant_d;
  logic [IDXW-1:0] prio_ptr;
  logic [XLEN-1:0] alu_a_q, alu_a_d;
  logic [XLEN-1:0] alu_b_q, alu_b_d;
  logic [3:0]      alu_ctrl_q, alu_ctrl_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            zero_q, zero_d;
  logic            win_found;
  logic [IDXW-1:0] win_idx;
  logic [IDXW-1:0] cand;

  // Scan from the priority pointer upward with wrap; first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDXW'((int'(prio_ptr) + int'(k)) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDXW-1:0] ptr_q, ptr_d;

  assign prio_ptr = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == RESP && rsp_ready[grant_q])
      ptr_d = (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  assign prio_ptr = '0;
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_ctrl_d = alu_ctrl_q;
    res_d      = res_q;
    zero_d     = zero_q;
    req_ready  = '0;
    rsp_valid  = '0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          req_ready[win_idx] = 1'b1;
          alu_a_d    = req_a[int'(win_idx)*XLEN +: XLEN];
          alu_b_d    = req_b[int'(win_idx)*XLEN +: XLEN];
          alu_ctrl_d = req_ctrl[int'(win_idx)*4 +: 4];
          grant_d    = win_idx;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_result;
        zero_d  = alu_zero;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid[grant_q] = 1'b1;
        if (rsp_ready[grant_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctrl_q <= '0;
      res_q      <= '0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_ctrl_q <= alu_ctrl_d;
      res_q      <= res_d;
      zero_q     <= zero_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed scenarios plus random traffic checked against a transaction-level model.
// Honours ARB_ROUND_ROBIN_EN the same way the design does.
module tb_alu_share_arbiter;
  localparam int XLEN    = 32;
  localparam int NUM_REQ = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_REQ-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NUM_REQ*XLEN-1:0] req_a, req_b;
  logic [NUM_REQ*4-1:0]    req_ctrl;
  logic [XLEN-1:0]         rsp_result, alu_a, alu_b, alu_result;
  logic                    rsp_zero, alu_zero, busy;
  logic [3:0]              alu_ctrl;

  always #5 clk = ~clk;

  alu_share_arbiter #(.XLEN(XLEN), .NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy)
  );

  // Bench ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, anything else returns 0 with zero set.
  function automatic logic [XLEN:0] alu_f(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                          input logic [3:0] c);
    logic [XLEN-1:0] r;
    case (c)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      default: r = '0;
    endcase
    return {(r == '0), r};
  endfunction

  assign {alu_zero, alu_result} = alu_f(alu_a, alu_b, alu_ctrl);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Transaction-level model state
  bit              m_known = 0;
  bit              m_inflight;
  int              m_grant, m_ptr, last_win;
  int unsigned     cyc = 0, m_acc;
  logic [XLEN-1:0] m_alu_a, m_alu_b, m_res, p_res;
  logic [3:0]      m_alu_ctrl;
  logic            m_zero, p_zero;

  function automatic int pick(input logic [NUM_REQ-1:0] v, input int p);
    for (int k = 0; k < NUM_REQ; k++)
      if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    return -1;
  endfunction

  // Called just after inputs are driven at a negedge; checks, advances the model past the posedge.
  task automatic cycle_check();
    int win;
    bit due;
    logic [NUM_REQ-1:0] exp_ready, exp_rv;
    #1;
    win = (m_known && !m_inflight) ? pick(req_valid, m_ptr) : -1;
    due = m_inflight && (cyc >= m_acc + 2);
    exp_ready = '0;
    exp_rv    = '0;
    if (win >= 0) exp_ready[win] = 1'b1;
    if (due) exp_rv[m_grant] = 1'b1;
    last_win = -1;
    if (!rst && m_known) begin
      check_eq("req_ready", 64'(req_ready), 64'(exp_ready));
      check_eq("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      check_eq("busy", 64'(busy), 64'(m_inflight));
      check_eq("alu_a", 64'(alu_a), 64'(m_alu_a));
      check_eq("alu_b", 64'(alu_b), 64'(m_alu_b));
      check_eq("alu_ctrl", 64'(alu_ctrl), 64'(m_alu_ctrl));
      check_eq("rsp_result", 64'(rsp_result), 64'(m_res));
      check_eq("rsp_zero", 64'(rsp_zero), 64'(m_zero));
    end
    if (rst) begin
      m_known = 1; m_inflight = 0; m_ptr = 0; m_grant = 0;
      m_alu_a = '0; m_alu_b = '0; m_alu_ctrl = '0; m_res = '0; m_zero = 1'b0;
    end else if (m_known) begin
      if (win >= 0) begin
        m_inflight = 1; m_grant = win; m_acc = cyc; last_win = win;
        m_alu_a    = req_a[win*XLEN +: XLEN];
        m_alu_b    = req_b[win*XLEN +: XLEN];
        m_alu_ctrl = req_ctrl[win*4 +: 4];
        {p_zero, p_res} = alu_f(m_alu_a, m_alu_b, m_alu_ctrl);
      end else if (m_inflight && cyc == m_acc + 1) begin
        m_res = p_res; m_zero = p_zero;
      end else if (due && rsp_ready[m_grant]) begin
        m_inflight = 0;
`ifdef ARB_ROUND_ROBIN_EN
        m_ptr = (m_grant + 1) % NUM_REQ;
`else
        m_ptr = 0;
`endif
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_op(input int i, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [3:0] c);
    req_a[i*XLEN +: XLEN] = a;
    req_b[i*XLEN +: XLEN] = b;
    req_ctrl[i*4 +: 4]    = c;
  endtask

  task automatic rand_op(input int i);
    logic [XLEN-1:0] a, b;
    a = ($urandom_range(0, 1) != 0) ? XLEN'($urandom_range(0, 15)) : XLEN'($urandom);
    b = ($urandom_range(0, 3) == 0) ? a : XLEN'($urandom_range(0, 15));
    set_op(i, a, b, ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15)));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle_check();
    rst = 1'b0;
  endtask

  int grants[$];

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0; req_ctrl = '0;
    last_win = -1;
    cycle_check();
    cycle_check();
    rst = 1'b0;

    // Reset state, idle
    #1;
    check_eq("t1_req_ready", 64'(req_ready), 64'd0);
    check_eq("t1_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("t1_busy", 64'(busy), 64'd0);
    check_eq("t1_alu_a", 64'(alu_a), 64'd0);
    check_eq("t1_alu_b", 64'(alu_b), 64'd0);
    check_eq("t1_alu_ctrl", 64'(alu_ctrl), 64'd0);
    cycle_check();
    cycle_check();

    // SUB 5-3
    set_op(0, 5, 3, 4'b0001); req_valid = 2'b01;
    cycle_check();
    req_valid = '0;
    cycle_check();
    rsp_ready = 2'b01;
    #1;
    check_eq("t2_rsp_valid", 64'(rsp_valid), 64'd1);
    check_eq("t2_result", 64'(rsp_result), 64'd2);
    check_eq("t2_zero", 64'(rsp_zero), 64'd0);
    cycle_check();
    rsp_ready = '0;
    cycle_check();

    // Undefined op code
    set_op(0, 7, 9, 4'b1111); req_valid = 2'b01;
    cycle_check();
    req_valid = '0;
    cycle_check();
    rsp_ready = 2'b01;
    #1;
    check_eq("t6_rsp_valid", 64'(rsp_valid), 64'd1);
    check_eq("t6_result", 64'(rsp_result), 64'd0);
    check_eq("t6_zero", 64'(rsp_zero), 64'd1);
    cycle_check();
    rsp_ready = '0;

    // Both requesters valid continuously
    do_reset();
    set_op(0, 1, 1, 4'd0); set_op(1, 32'hF0, 32'h0F, 4'd2);
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int n = 0; n < 14; n++) begin
      #1;
      if (rsp_valid == 2'b01) begin
        check_eq("t3_res0", 64'(rsp_result), 64'd2);
        check_eq("t3_zero0", 64'(rsp_zero), 64'd0);
      end else if (rsp_valid == 2'b10) begin
        check_eq("t3_res1", 64'(rsp_result), 64'd0);
        check_eq("t3_zero1", 64'(rsp_zero), 64'd1);
      end
      cycle_check();
      if (last_win >= 0) grants.push_back(last_win);
    end
    check_eq("t3_ngrants", 64'(grants.size() >= 4), 64'd1);
    for (int n = 0; n < 4 && n < grants.size(); n++) begin
`ifdef ARB_ROUND_ROBIN_EN
      check_eq("t3_order", 64'(grants[n]), 64'(n % 2));
`else
      check_eq("t3_order", 64'(grants[n]), 64'd0);
`endif
    end
    req_valid = '0; rsp_ready = '0;

    // Back-pressure on the response; non-granted rsp_ready is ignored
    do_reset();
    set_op(0, 10, 20, 4'd0); set_op(1, 6, 2, 4'd1);
    req_valid = 2'b11;
    cycle_check();
    req_valid = 2'b10; rsp_ready = 2'b10;
    cycle_check();
    for (int n = 0; n < 5; n++) begin
      #1;
      check_eq("t4_rsp_valid", 64'(rsp_valid), 64'd1);
      check_eq("t4_result", 64'(rsp_result), 64'd30);
      check_eq("t4_req_ready", 64'(req_ready), 64'd0);
      cycle_check();
    end
    rsp_ready = 2'b11;
    cycle_check();
    #1;
    check_eq("t4_next_ready", 64'(req_ready), 64'd2);
    cycle_check();
    req_valid = '0;
    cycle_check();
    cycle_check();
    rsp_ready = '0;

    // Reset during EXEC aborts the operation
    do_reset();
    set_op(1, 1, 2, 4'd3); req_valid = 2'b10; rsp_ready = 2'b10;
    cycle_check();
    req_valid = '0;
    rst = 1'b1;
    cycle_check();
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      check_eq("t5_rsp_valid", 64'(rsp_valid), 64'd0);
      check_eq("t5_busy", 64'(busy), 64'd0);
      cycle_check();
    end
    req_valid = 2'b10;
    cycle_check();
    req_valid = '0;
    cycle_check();
    #1;
    check_eq("t5_rsp_valid2", 64'(rsp_valid), 64'd2);
    check_eq("t5_result", 64'(rsp_result), 64'd3);
    cycle_check();
    rsp_ready = '0;

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (last_win == i) begin
          req_valid[i] = ($urandom_range(0, 1) != 0);
          if (req_valid[i]) rand_op(i);
        end else if (req_valid[i]) begin
          if ($urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 9) < 4) begin
          rand_op(i);
          req_valid[i] = 1'b1;
        end
        rsp_ready[i] = ($urandom_range(0, 9) < 6);
      end
      rst = ($urandom_range(0, 399) == 0);
      cycle_check();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
